// File: rtl/instr_fetch_stage.sv
// Fetch stage: issues imem reads at pc_curr, tags each reply with its PC and
// buffers it for decode; redirects flush the buffer and drop in-flight replies.
module instr_fetch_stage #(
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          FIFO_DEPTH      = 2,
    parameter logic [31:0] NOP_INSTR       = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_curr,
    output logic        pc_en,
    output logic        pc_load_en,
    output logic [31:0] pc_load_val,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        if_fault
);
    localparam int OW  = $clog2(MAX_OUTSTANDING) + 1;
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int TAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int SW  = ((OW > CW) ? OW : CW) + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } entry_t;

    logic [31:0]    tag_q [MAX_OUTSTANDING];
    logic [TAW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [OW-1:0]  outstanding_q, outstanding_d;
    logic [OW-1:0]  drop_cnt_q, drop_cnt_d;
    entry_t         fifo_q [FIFO_DEPTH];
    logic [FAW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [CW-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic           halted_q, halted_d;

    logic   aligned, credit_ok, fire, rsp_keep, misalign_push, push, pop;
    entry_t push_entry;

    function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
        return (p == TAW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pc_load_en    = redirect_valid;
    assign pc_load_val   = redirect_pc;
    assign imem_req_addr = pc_curr;

    assign aligned   = (pc_curr[1:0] == 2'b00);
    assign credit_ok = ((SW'(outstanding_q) + SW'(fifo_cnt_q)) < SW'(FIFO_DEPTH)) &&
                       (outstanding_q < OW'(MAX_OUTSTANDING));

    assign imem_req_valid = !rst && !redirect_valid && !halted_q && aligned && credit_ok;
    assign fire           = imem_req_valid && imem_req_ready;
    assign pc_en          = fire;

    assign rsp_keep = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);

    // The fault entry waits for all older replies so it stays in program order
    // and never competes with a response for the single push port.
    assign misalign_push = !rst && !redirect_valid && !halted_q && !aligned &&
                           (outstanding_q == '0) && (fifo_cnt_q < CW'(FIFO_DEPTH));

    assign push = rsp_keep || misalign_push;
    assign pop  = if_valid && if_ready && !redirect_valid;

    assign if_valid = (fifo_cnt_q != '0);
    assign if_pc    = fifo_q[fifo_rd_q].pc;
    assign if_instr = fifo_q[fifo_rd_q].instr;
    assign if_fault = fifo_q[fifo_rd_q].fault;

    always_comb begin
        push_entry = '{pc: tag_q[tag_rd_q], instr: imem_rsp_data, fault: imem_rsp_err};
        if (misalign_push) begin
            push_entry = '{pc: pc_curr, instr: NOP_INSTR, fault: 1'b1};
        end
    end

    always_comb begin
        outstanding_d = outstanding_q + OW'(fire) - OW'(imem_rsp_valid);
        tag_wr_d      = fire ? tag_inc(tag_wr_q) : tag_wr_q;
        tag_rd_d      = imem_rsp_valid ? tag_inc(tag_rd_q) : tag_rd_q;
        drop_cnt_d    = drop_cnt_q;
        fifo_wr_d     = fifo_wr_q;
        fifo_rd_d     = fifo_rd_q;
        fifo_cnt_d    = fifo_cnt_q;
        halted_d      = halted_q;
        if (redirect_valid) begin
            // outstanding_q already counts replies that were stale before this
            // redirect, so everything still in flight afterwards gets dropped.
            drop_cnt_d = outstanding_q - OW'(imem_rsp_valid);
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
            halted_d   = 1'b0;
        end else begin
            if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            if (push) begin
                fifo_wr_d = fifo_wr_q + 1'b1;
            end
            if (pop) begin
                fifo_rd_d = fifo_rd_q + 1'b1;
            end
            fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
            if ((rsp_keep && imem_rsp_err) || misalign_push) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                tag_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            tag_wr_q      <= '0;
            tag_rd_q      <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            fifo_wr_q     <= '0;
            fifo_rd_q     <= '0;
            fifo_cnt_q    <= '0;
            halted_q      <= 1'b0;
        end else begin
            if (fire) begin
                tag_q[tag_wr_q] <= pc_curr;
            end
            if (push) begin
                fifo_q[fifo_wr_q] <= push_entry;
            end
            tag_wr_q      <= tag_wr_d;
            tag_rd_q      <= tag_rd_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            fifo_wr_q     <= fifo_wr_d;
            fifo_rd_q     <= fifo_rd_d;
            fifo_cnt_q    <= fifo_cnt_d;
            halted_q      <= halted_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: a PC register and in-order memory model drive the
// DUT, expected decode entries are queued at request time and popped on delivery.
module tb_instr_fetch_stage;
    localparam int MAXO  = 2;
    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_curr;
    logic        pc_en, pc_load_en;
    logic [31:0] pc_load_val;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        if_valid, if_ready;
    logic [31:0] if_pc, if_instr;
    logic        if_fault;

    always #5 clk = ~clk;

    instr_fetch_stage dut (
        .clk(clk), .rst(rst), .pc_curr(pc_curr), .pc_en(pc_en),
        .pc_load_en(pc_load_en), .pc_load_val(pc_load_val),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instr(if_instr), .if_fault(if_fault)
    );

    typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } exp_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    exp_t  sb[$];
    mreq_t memq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fifoM, dropM, lat, pops, faultPops, fires, dutOut, maxDutOut;
    logic        haltM, errArm;
    logic [31:0] pcModel, errAddr, firstPc;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic startPhase();
        pops = 0;
        faultPops = 0;
        fires = 0;
        maxDutOut = 0;
        firstPc = 'x;
    endtask

    task automatic applyReset(input logic [31:0] startPc);
        rst = 1'b1;
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        imem_rsp_err = 1'b0;
        pcModel = startPc;
        pc_curr = startPc;
        memq.delete();
        sb.delete();
        fifoM = 0;
        dropM = 0;
        dutOut = 0;
        haltM = 1'b0;
        errArm = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
        checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
        checkOutput("rst_if_fault", 32'(if_fault), 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'd0);
        checkOutput("rst_if_instr", if_instr, 32'd0);
        rst = 1'b0;
    endtask

    // One clock: drive the memory reply, check the DUT against the model, advance.
    task automatic stepCycle();
        mreq_t r;
        exp_t  e;
        logic  rspNow, rspErr, expReq, fireM, kept, misPush, redir;
        int    outstM;
        outstM = memq.size();
        rspNow = 1'b0;
        rspErr = 1'b0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            r = memq.pop_front();
            rspNow = 1'b1;
            rspErr = errArm && (r.addr == errAddr);
            imem_rsp_valid = 1'b1;
            imem_rsp_data = memData(r.addr);
            imem_rsp_err = rspErr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data = '0;
            imem_rsp_err = 1'b0;
        end
        #1;
        redir = redirect_valid;
        expReq = !redir && !haltM && (pcModel[1:0] == 2'b00) &&
                 (outstM + fifoM < DEPTH) && (outstM < MAXO);
        fireM = expReq && imem_req_ready;
        checkOutput("req_valid", 32'(imem_req_valid), 32'(expReq));
        checkOutput("pc_en", 32'(pc_en), 32'(fireM));
        checkOutput("req_addr", imem_req_addr, pcModel);
        checkOutput("pc_load_en", 32'(pc_load_en), 32'(redir));
        checkOutput("pc_load_val", pc_load_val, redirect_pc);
        checkOutput("if_valid", 32'(if_valid), 32'(fifoM != 0));
        if (pc_en === 1'b1) fires++;
        dutOut = dutOut + ((pc_en === 1'b1) ? 1 : 0) - (rspNow ? 1 : 0);
        if (dutOut > maxDutOut) maxDutOut = dutOut;
        if (if_valid === 1'b1 && if_ready && !redir && sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("if_pc", if_pc, e.pc);
            checkOutput("if_instr", if_instr, e.instr);
            checkOutput("if_fault", 32'(if_fault), 32'(e.fault));
            if (pops == 0) firstPc = if_pc;
            if (if_fault === 1'b1) faultPops++;
            pops++;
            fifoM--;
        end
        misPush = !redir && !haltM && (pcModel[1:0] != 2'b00) && (outstM == 0) && (fifoM < DEPTH);
        if (redir) begin
            sb.delete();
            fifoM = 0;
            dropM = memq.size();
            haltM = 1'b0;
        end else begin
            kept = rspNow && (dropM == 0);
            if (rspNow && dropM > 0) dropM--;
            if (kept) fifoM++;
            if (kept && rspErr) haltM = 1'b1;
            if (misPush) begin
                sb.push_back('{pc: pcModel, instr: NOP, fault: 1'b1});
                fifoM++;
                haltM = 1'b1;
            end
            if (fireM) begin
                memq.push_back('{addr: pcModel, due: cyc + lat});
                sb.push_back('{pc: pcModel, instr: memData(pcModel),
                               fault: errArm && (pcModel == errAddr)});
            end
        end
        @(posedge clk);
        #1;
        if (redir) pcModel = redirect_pc;
        else if (fireM) pcModel = pcModel + 32'd4;
        pc_curr = pcModel;
        cyc++;
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    initial begin
        $display("[TB] fetch stage bench start");
        imem_req_ready = 1'b1;
        if_ready = 1'b1;
        redirect_pc = '0;
        errAddr = 32'hFFFF_FFFF;
        lat = 1;

        // Streaming with 1-cycle memory.
        applyReset(32'h8000_0000);
        startPhase();
        applyStimulus(12);
        checkOutput("t1_deliveries", 32'(pops >= 6), 32'd1);
        checkOutput("t1_first_pc", firstPc, 32'h8000_0000);

        // Decode stalled: only FIFO_DEPTH requests may go out.
        applyReset(32'h8000_0000);
        startPhase();
        if_ready = 1'b0;
        applyStimulus(8);
        checkOutput("t2_fires", 32'(fires), 32'(DEPTH));
        checkOutput("t2_req_blocked", 32'(imem_req_valid), 32'd0);
        checkOutput("t2_pc_en_blocked", 32'(pc_en), 32'd0);
        if_ready = 1'b1;
        startPhase();
        applyStimulus(10);
        checkOutput("t2_drain_first", firstPc, 32'h8000_0000);
        checkOutput("t2_resumed", 32'(fires > 0), 32'd1);
        checkOutput("t2_drained", 32'(pops >= 3), 32'd1);

        // 3-cycle memory with a short request stall.
        applyReset(32'h8000_0000);
        lat = 3;
        startPhase();
        applyStimulus(10);
        imem_req_ready = 1'b0;
        applyStimulus(3);
        imem_req_ready = 1'b1;
        applyStimulus(17);
        checkOutput("t3_max_inflight", 32'(maxDutOut <= MAXO), 32'd1);
        checkOutput("t3_deliveries", 32'(pops >= 5), 32'd1);
        checkOutput("t3_first_pc", firstPc, 32'h8000_0000);

        // Redirect with two replies in flight.
        applyReset(32'h8000_0000);
        startPhase();
        for (int i = 0; i < 10 && memq.size() != 2; i++) stepCycle();
        checkOutput("t4_two_inflight", 32'(memq.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        stepCycle();
        redirect_valid = 1'b0;
        checkOutput("t4_flushed", 32'(if_valid), 32'd0);
        startPhase();
        for (int i = 0; i < 20 && pops == 0; i++) stepCycle();
        checkOutput("t4_first_pc", firstPc, 32'h8000_0100);
        applyStimulus(6);

        // Bus error halts fetch until a redirect.
        applyReset(32'h8000_0000);
        lat = 1;
        errAddr = 32'h8000_0008;
        errArm = 1'b1;
        startPhase();
        applyStimulus(12);
        checkOutput("t5_fault_seen", 32'(faultPops), 32'd1);
        checkOutput("t5_halted", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        stepCycle();
        redirect_valid = 1'b0;
        errArm = 1'b0;
        startPhase();
        for (int i = 0; i < 20 && pops == 0; i++) stepCycle();
        checkOutput("t5_resume_pc", firstPc, 32'h8000_0200);

        // Misaligned PC produces a fault entry and no request.
        applyReset(32'h8000_0002);
        startPhase();
        applyStimulus(4);
        checkOutput("t6_fault_seen", 32'(faultPops), 32'd1);
        checkOutput("t6_fault_pc", firstPc, 32'h8000_0002);
        checkOutput("t6_no_fires", 32'(fires), 32'd0);
        checkOutput("t6_halted", 32'(imem_req_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: bench did not finish");
        $fatal(1, "[TB] timeout");
    end
endmodule
